serial_add: RTL and testbench
=============================

Name: serial_add

Overview:
- Bit-serial adder for two WIDTH-bit unsigned operands.
- A load cycle captures both operands into internal shift registers and clears the carry.
- Each following shift cycle emits one registered sum bit, LSB first, then the final carry-out.
- Leaf datapath block. Whatever drives `mode` sequences the operation; this block has no handshake beyond `mode`.

Parameters:
- WIDTH, default 16: operand width in bits (must be ≥ 2).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- mode  input  1  1 = load operands; 0 = shift/add one bit.
- a  input  WIDTH  operand A; sampled only on load cycles.
- b  input  WIDTH  operand B; sampled only on load cycles.
- sum  output  1  registered serial sum bit, LSB first.

Behaviour:
- Internal state:
  - `sr_a`, `sr_b`: WIDTH-bit shift registers.
  - `carry`: 1 bit.
  - `sum_q`: 1 bit, drives `sum`.
  - `cnt`: bit counter, range 0..WIDTH+1, saturating.
- Priority each rising edge: reset > mode=1 (load) > mode=0 (shift).
- Reset, sampled high at an edge:
  - `sr_a`, `sr_b`, `carry`, `sum_q` and `cnt` all go to 0.
  - `sum` reads 0 from the next edge onward.
  - Reset holds the block cleared for as long as it stays high.
  - A mid-operation reset discards the operation in progress.
- Load (mode=1, reset=0):
  - `sr_a` <= a; `sr_b` <= b; `carry` <= 0; `sum_q` <= 0; `cnt` <= 0.
  - Consecutive load cycles are legal; the last one wins.
  - A load during a shift sequence aborts it and restarts with the new operands.
- Shift (mode=0, reset=0):
  - `sum_q` <= `sr_a[0]` ^ `sr_b[0]` ^ `carry`.
  - `carry` <= majority(`sr_a[0]`, `sr_b[0]`, `carry`).
  - `sr_a` and `sr_b` shift right by one, filling 0 at the MSB.
  - `cnt` increments, saturating at WIDTH+1.
- Latency:
  - After the shift edge numbered k (k = 1..WIDTH following a load), `sum` equals bit k-1 of (a+b).
  - Shift edge WIDTH+1 presents the carry-out, i.e. bit WIDTH of the (WIDTH+1)-bit true sum.
  - Every later shift edge presents 0, because the registers are zero-filled and the carry is consumed.
- Arithmetic: unsigned modulo 2^(WIDTH+1). No overflow flag; the carry-out appears serially as the (WIDTH+1)-th bit.
- Operands `a` and `b` may change freely while mode=0; they are ignored.
- Shifting without a prior load after reset adds 0+0 and yields `sum`=0 indefinitely.
- `cnt` is internal only. It exists for assertion and coverage hooks and has no effect on outputs.
- No combinational path from any input to `sum`.

Decomposition:
- Shared package:
  - `SER_ADD_WIDTH_DEFAULT` = 16.
  - `MODE_LOAD` = 1'b1.
  - `MODE_SHIFT` = 1'b0.
- One natural sub-module, `full_adder_bit`: combinational a, b, cin -> s, cout. It is instantiated once for the serial bit slice.
- Shift registers and control stay in the top module.

Test Plan:
- Reset: hold reset=1 for 2 cycles with random a/b/mode -> `sum`=0 after each edge; the first shift after release gives 0.
- No carry: load a=0x1111, b=0x1111, then 17 shift cycles -> `sum` sequence LSB-first is the bits of 0x2222 (0,1,0,0,0,1,0,0,0,1,0,0,0,1,0,0), followed by carry-out 0.
- Full ripple: load a=0xFFFF, b=0x0001, then 18 shifts -> 16 zeros, then 1 (carry-out), then 0.
- Double load: load a=0x00FF, b=0x0001, then load a=0x0003, b=0x0005 on the next cycle, then 16 shifts -> serial bits of 0x0008 only.
- Reset mid-operation: load a=0xAAAA, b=0x5555, shift 5 cycles, assert reset 1 cycle, then shift 4 -> `sum`=0 on all 4.
- Reload mid-operation: after 7 shifts of a=0x1234+0x4321, load a=0x8000, b=0x8000 -> bits 0..15 of the next 17 shifts are 0, and bit 16 = 1.

Source files
------------

// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared constants for the bit-serial adder
package serial_add_pkg;

    localparam int   SER_ADD_WIDTH_DEFAULT = 16;
    localparam logic MODE_LOAD             = 1'b1;
    localparam logic MODE_SHIFT            = 1'b0;

endpackage

// File: rtl/serial_add_full_adder_bit.sv
// rtl/serial_add_full_adder_bit.sv - one-bit combinational full adder slice
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add.sv
// rtl/serial_add.sv - bit-serial unsigned adder, LSB first, carry-out as final bit
module serial_add
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SER_ADD_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             sum
);

    localparam int CNT_W = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH + 1);

    logic [WIDTH-1:0] sr_a;
    logic [WIDTH-1:0] sr_b;
    logic             carry;
    logic             sum_q;
    logic [CNT_W-1:0] cnt;
    logic             fa_s;
    logic             fa_cout;

    full_adder_bit u_fa (
        .a    (sr_a[0]),
        .b    (sr_b[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // Zero-fill on shift so the carry-out emerges once and zeros follow.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_a  <= '0;
            sr_b  <= '0;
            carry <= 1'b0;
            sum_q <= 1'b0;
            cnt   <= '0;
        end else if (mode == MODE_LOAD) begin
            sr_a  <= a;
            sr_b  <= b;
            carry <= 1'b0;
            sum_q <= 1'b0;
            cnt   <= '0;
        end else begin
            sr_a  <= {1'b0, sr_a[WIDTH-1:1]};
            sr_b  <= {1'b0, sr_b[WIDTH-1:1]};
            carry <= fa_cout;
            sum_q <= fa_s;
            if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign sum = sum_q;

endmodule

// File: tb/tb_serial_add.sv
// tb/tb_serial_add.sv - directed self-checking bench for serial_add
module tb_serial_add;

    logic        clk = 1'b0;
    logic        reset;
    logic        mode;
    logic [15:0] a;
    logic [15:0] b;
    logic        sum;

    int checks   = 0;
    int failures = 0;

    logic [16:0] exp_v;

    serial_add #(.WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .mode  (mode),
        .a     (a),
        .b     (b),
        .sum   (sum)
    );

    always #5 clk = ~clk;

    task automatic tick(input logic r, input logic m, input logic [15:0] av, input logic [15:0] bv);
        @(negedge clk);
        reset = r;
        mode  = m;
        a     = av;
        b     = bv;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int idx, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s[%0d] observed=%b expected=%b", tag, idx, obs, exp);
        end
    endtask

    task automatic shift_chk(input string tag, input int n, input logic [16:0] vec);
        logic [15:0] junk_a;
        logic [15:0] junk_b;
        for (int k = 0; k < n; k++) begin
            junk_a = 16'($urandom);
            junk_b = 16'($urandom);
            tick(1'b0, 1'b0, junk_a, junk_b);
            chk(tag, k, sum, (k <= 16) ? vec[k] : 1'b0);
        end
    endtask

    initial begin
        reset = 1'b1;
        mode  = 1'b0;
        a     = '0;
        b     = '0;

        // Reset held two cycles with random inputs
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 1'($urandom), 16'($urandom), 16'($urandom));
            chk("reset_hold", i, sum, 1'b0);
        end
        tick(1'b0, 1'b0, 16'hBEEF, 16'hCAFE);
        chk("first_shift", 0, sum, 1'b0);

        // 0x1111 + 0x1111 = 0x02222
        tick(1'b0, 1'b1, 16'h1111, 16'h1111);
        chk("load_nc", 0, sum, 1'b0);
        exp_v = 17'h02222;
        shift_chk("no_carry", 17, exp_v);

        // 0xFFFF + 0x0001 = 0x10000, then trailing zero
        tick(1'b0, 1'b1, 16'hFFFF, 16'h0001);
        exp_v = 17'h10000;
        shift_chk("ripple", 18, exp_v);

        // Second of two consecutive loads wins: 3 + 5 = 8
        tick(1'b0, 1'b1, 16'h00FF, 16'h0001);
        tick(1'b0, 1'b1, 16'h0003, 16'h0005);
        chk("dbl_load", 0, sum, 1'b0);
        exp_v = 17'h00008;
        shift_chk("double_load", 16, exp_v);

        // Reset in the middle of 0xAAAA + 0x5555 = 0x0FFFF
        tick(1'b0, 1'b1, 16'hAAAA, 16'h5555);
        exp_v = 17'h0FFFF;
        shift_chk("pre_reset", 5, exp_v);
        tick(1'b1, 1'b0, 16'h0000, 16'h0000);
        chk("mid_reset", 0, sum, 1'b0);
        exp_v = 17'h00000;
        shift_chk("post_reset", 4, exp_v);

        // Reload after 7 shifts of 0x1234 + 0x4321 = 0x05555
        tick(1'b0, 1'b1, 16'h1234, 16'h4321);
        exp_v = 17'h05555;
        shift_chk("pre_reload", 7, exp_v);
        tick(1'b0, 1'b1, 16'h8000, 16'h8000);
        chk("reload", 0, sum, 1'b0);
        exp_v = 17'h10000;
        shift_chk("reload_sum", 17, exp_v);

        // Saturated past the carry-out: stays zero
        exp_v = 17'h00000;
        shift_chk("tail_zero", 3, exp_v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
